// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle of the MEM-stage SRAM sequencer.
// The master is the pipeline's MEM stage; the slave is the sequencer.
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// MEM-stage data-memory sequencer: each 32-bit access becomes two 16-bit SRAM
// phases (low half first) while `ready` freezes the pipeline.
module sram_controller #(
    parameter int          PHASE_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE    = 32'd1024
) (
    input  logic                      clk,
    input  logic                      rst,
    sram_controller_if.slave          bus,
    output logic [17:0]               sram_addr,
    output logic [15:0]               sram_dq_o,
    input  logic [15:0]               sram_dq_i,
    output logic                      sram_dq_oe,
    output logic                      sram_we_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] PHASE_LOAD = 4'(PHASE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] read_data_q, read_data_d;

    logic [31:0] off;
    logic [16:0] word_idx;
    logic        req;
    logic        ready;
    logic        unused_bits;

    assign off         = bus.address - ADDR_BASE;
    assign word_idx    = off[18:2];
    assign unused_bits = ^{off[31:19], off[1:0]};
    assign req         = bus.rd_en | bus.wr_en;

    assign bus.read_data = read_data_q;
    assign bus.ready     = ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        ready       = 1'b0;
        sram_addr   = 18'd0;
        sram_dq_o   = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    is_wr_d = bus.wr_en;
                    state_d = LOW;
                    cnt_d   = PHASE_LOAD;
                end
            end
            LOW: begin
                sram_addr  = {word_idx, 1'b0};
                sram_we_n  = ~is_wr_q;
                sram_dq_oe = is_wr_q;
                sram_dq_o  = is_wr_q ? bus.write_data[15:0] : 16'd0;
                if (cnt_q == 4'd0) begin
                    if (!is_wr_q) read_data_d[15:0] = sram_dq_i;
                    state_d = HIGH;
                    cnt_d   = PHASE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HIGH: begin
                sram_addr  = {word_idx, 1'b1};
                sram_we_n  = ~is_wr_q;
                sram_dq_oe = is_wr_q;
                sram_dq_o  = is_wr_q ? bus.write_data[31:16] : 16'd0;
                if (cnt_q == 4'd0) begin
                    if (!is_wr_q) read_data_d[31:16] = sram_dq_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Single release cycle; the next instruction is seen in IDLE.
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: P=2 instance on a small SRAM model,
// plus P=1 and P=15 instances for stall-length checks.
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_controller_if if2 ();
    sram_controller_if if1 ();
    sram_controller_if if15 ();

    assign if2.rd_en = rd_en;   assign if2.wr_en = wr_en;
    assign if2.address = address; assign if2.write_data = write_data;
    assign if1.rd_en = rd_en;   assign if1.wr_en = wr_en;
    assign if1.address = address; assign if1.write_data = write_data;
    assign if15.rd_en = rd_en;  assign if15.wr_en = wr_en;
    assign if15.address = address; assign if15.write_data = write_data;

    logic [17:0] sram_addr, a1, a15;
    logic [15:0] sram_dq_o, sram_dq_i, d1, d15;
    logic        sram_dq_oe, sram_we_n, oe1, oe15, we1, we15;

    logic [15:0] mem [0:63];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_o;
    assign sram_dq_i = mem[sram_addr[5:0]];

    sram_controller #(.PHASE_CYCLES(2), .ADDR_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .bus(if2.slave),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n));

    sram_controller #(.PHASE_CYCLES(1), .ADDR_BASE(32'd1024)) dut_p1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .sram_addr(a1), .sram_dq_o(d1), .sram_dq_i(16'h0000),
        .sram_dq_oe(oe1), .sram_we_n(we1));

    sram_controller #(.PHASE_CYCLES(15), .ADDR_BASE(32'd1024)) dut_p15 (
        .clk(clk), .rst(rst), .bus(if15.slave),
        .sram_addr(a15), .sram_dq_o(d15), .sram_dq_i(16'h0000),
        .sram_dq_oe(oe15), .sram_we_n(we15));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One P=2 access: cycle 0 in IDLE, 1-2 LOW, 3-4 HIGH, 5 DONE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [17:0] lo,
                          input logic [31:0] exp_rd, input string tag);
        logic [31:0] e_addr, e_dq;
        logic        e_we_n;
        rd_en = rd; wr_en = wr; address = a; write_data = wd;
        #1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            e_addr = 32'd0; e_dq = 32'd0; e_we_n = 1'b1;
            if (c == 1 || c == 2) begin
                e_addr = {14'd0, lo};
                if (wr) begin e_we_n = 1'b0; e_dq = {16'd0, wd[15:0]}; end
            end else if (c == 3 || c == 4) begin
                e_addr = {14'd0, lo} + 32'd1;
                if (wr) begin e_we_n = 1'b0; e_dq = {16'd0, wd[31:16]}; end
            end
            chk($sformatf("%s c%0d ready", tag, c), {31'd0, if2.ready}, {31'd0, c == 5});
            chk($sformatf("%s c%0d addr", tag, c), {14'd0, sram_addr}, e_addr);
            chk($sformatf("%s c%0d we_n", tag, c), {31'd0, sram_we_n}, {31'd0, e_we_n});
            chk($sformatf("%s c%0d oe", tag, c), {31'd0, sram_dq_oe}, {31'd0, ~e_we_n});
            chk($sformatf("%s c%0d dq_o", tag, c), {16'd0, sram_dq_o}, e_dq);
            if (c == 5 && !wr)
                chk($sformatf("%s read_data", tag), if2.read_data, exp_rd);
        end
        tick();
    endtask

    initial begin
        int cnt1, cnt15, bad;
        logic done1, done15;

        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset ready", {31'd0, if2.ready}, 32'd1);
        chk("reset read_data", if2.read_data, 32'd0);
        chk("reset we_n", {31'd0, sram_we_n}, 32'd1);
        chk("reset oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("reset addr", {14'd0, sram_addr}, 32'd0);
        chk("reset dq_o", {16'd0, sram_dq_o}, 32'd0);

        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'd0, "wr1032");
        rd_en = 1'b0; wr_en = 1'b0;
        chk("mem4", {16'd0, mem[4]}, 32'h0000BEEF);
        chk("mem5", {16'd0, mem[5]}, 32'h0000DEAD);
        tick();

        access(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 32'hDEADBEEF, "rd1032");

        // Back-to-back: read follows immediately after DONE.
        access(1'b0, 1'b1, 32'd1024, 32'h11112222, 18'd0, 32'd0, "b2b_wr");
        chk("read_data after write", if2.read_data, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'h11112222, "b2b_rd");

        access(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 18'd2, 32'd0, "both");
        rd_en = 1'b0; wr_en = 1'b0;
        chk("both mem2", {16'd0, mem[2]}, 32'h00005A5A);
        chk("both mem3", {16'd0, mem[3]}, 32'h0000A5A5);
        chk("both read_data kept", if2.read_data, 32'h11112222);
        tick();

        // Reset during HIGH of a read.
        rd_en = 1'b1; address = 32'd1032;
        tick(); tick(); tick();
        chk("rst_mid in HIGH", {14'd0, sram_addr}, 32'd5);
        rst = 1'b1;
        tick();
        chk("rst_mid read_data", if2.read_data, 32'd0);
        chk("rst_mid we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_mid addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_mid ready", {31'd0, if2.ready}, 32'd0);
        rst = 1'b0; rd_en = 1'b0;
        #1;
        chk("rst_mid idle ready", {31'd0, if2.ready}, 32'd1);
        chk("rst_mid mem4", {16'd0, mem[4]}, 32'h0000BEEF);
        chk("rst_mid mem5", {16'd0, mem[5]}, 32'h0000DEAD);
        access(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 32'hDEADBEEF, "rd_after_rst");
        rd_en = 1'b0;

        // Stall length for P=1 and P=15.
        rst = 1'b1; tick(); rst = 1'b0;
        rd_en = 1'b1; address = 32'd1024;
        #1;
        cnt1 = 0; cnt15 = 0; done1 = 1'b0; done15 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!done1) begin if (if1.ready) done1 = 1'b1; else cnt1++; end
            if (!done15) begin if (if15.ready) done15 = 1'b1; else cnt15++; end
            if (done1 && done15) break;
            tick();
        end
        chk("p1 released", {31'd0, done1}, 32'd1);
        chk("p15 released", {31'd0, done15}, 32'd1);
        chk("p1 stall cycles", cnt1, 32'd3);
        chk("p15 stall cycles", cnt15, 32'd31);

        rd_en = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!(if1.ready && if2.ready && if15.ready)) bad++;
        end
        chk("idle ready constant", bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory access sequencer for the MEM stage of the pipelined core. It takes the stage's MEM_R/MEM_W request, address and store data and performs each 32-bit access as two 16-bit accesses on the external SRAM, low half first. While an access is in flight it deasserts `ready`; the hazard/freeze logic uses `ready` to stall every pipeline register and the PC. Load data is returned on `read_data` for write-back.

## Interface
- `PHASE_CYCLES`, 2: cycles each 16-bit half-access holds address, data and strobes; legal range 1..15.
- `ADDR_BASE`, 1024: byte address of data-memory word 0; subtracted before translation.

- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `rd_en`  in  1  load request (MEM_R); held stable while `ready`=0
- `wr_en`  in  1  store request (MEM_W); held stable while `ready`=0
- `address`  in  32  byte address from ALU result
- `write_data`  in  32  store data (Val_Rm)
- `read_data`  out  32  registered load data
- `ready`  out  1  1 = stage may advance; 0 = freeze pipeline
- `sram_addr`  out  18  SRAM half-word address
- `sram_dq_o`  out  16  SRAM write data
- `sram_dq_i`  in  16  SRAM read data
- `sram_dq_oe`  out  1  1 = drive `sram_dq_o` onto the bus
- `sram_we_n`  out  1  SRAM write strobe, active low

## Operation
- Effective offset `off = address - ADDR_BASE`, modulo 2^32. Word index is `off[18:2]`. Low half is at `{off[18:2],1'b0}` and high half at `{off[18:2],1'b1}`. Offset bits [1:0] are ignored. There is no range check.
- Request `req = rd_en | wr_en`. If both are set, the access is a write.
- FSM states:
  - IDLE: `ready = ~req` (combinational). If req is set, latch the op type, go to LOW and load the phase counter.
  - LOW: low-half phase. Stay for PHASE_CYCLES cycles, then go to HIGH.
  - HIGH: high-half phase. Stay for PHASE_CYCLES cycles, then go to DONE.
  - DONE: `ready=1` for exactly one cycle, then go to IDLE unconditionally.
- The phase counter is 4 bits. It loads PHASE_CYCLES-1 on entry to LOW or HIGH, decrements each cycle, and the phase ends when it reaches 0.
- Signals in LOW/HIGH:
  - `sram_addr` = the corresponding half address.
  - Write op: `sram_we_n`=0, `sram_dq_oe`=1, and `sram_dq_o` = `write_data[15:0]` in LOW or `write_data[31:16]` in HIGH.
  - Read op: `sram_we_n`=1 and `sram_dq_oe`=0.
- Signals in IDLE/DONE: `sram_addr`=0, `sram_dq_o`=0, `sram_we_n`=1, `sram_dq_oe`=0.
- Read capture: on the last cycle of LOW, `sram_dq_i` goes into `read_data[15:0]`. On the last cycle of HIGH, it goes into `read_data[31:16]`.
- `read_data` holds its value until the next read captures. Writes never modify it.

## Timing
- Reset values: state IDLE, counter 0, `read_data`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_o`=0. `ready` = ~req, since the reset state is IDLE.
- Cycle numbering for one request, where cycle 0 is the first cycle the request is seen in IDLE:
  - cycles 1..P are LOW;
  - cycles P+1..2P are HIGH;
  - cycle 2P+1 is DONE.
- `ready`=0 for 2P+1 cycles (cycles 0..2P). It is 1 in cycle 2P+1, and the pipeline advances on that cycle's edge.
- Load data is valid on `read_data` from cycle 2P+1 onward.
- Back-to-back requests: the instruction arriving after DONE is seen in IDLE, with no extra gap cycle. The total period per access is 2P+2 cycles.
- Request dropping mid-access (illegal) is ignored. The access completes with the latched op type, using the live `address` and `write_data`.
- `rst` in any state: IDLE on the next edge, all outputs at reset values, and any partially captured `read_data` is cleared.
- With no request, the FSM stays in IDLE and `ready` stays 1 indefinitely.

## Test plan
- Write, P=2: `wr_en`=1, `address`=1032, `write_data`=0xDEADBEEF.
  - SRAM model receives 0xBEEF at addr 4 (cycles 1-2) and 0xDEAD at addr 5 (cycles 3-4).
  - `ready` is 0 for cycles 0-4 and 1 at cycle 5.
- Read back, P=2: `rd_en`=1, `address`=1032.
  - `read_data`=0xDEADBEEF at cycle 5, with `sram_we_n`=1 throughout.
  - `read_data` is unchanged by a following write.
- Back-to-back: a write to 1024 (0x11112222) immediately followed by a read of 1024.
  - The second access starts on the cycle after DONE.
  - `read_data`=0x11112222.
  - `ready` pattern is 0,0,0,0,0,1,0,0,0,0,0,1.
- Both `rd_en` and `wr_en`=1 at 1028 with 0xA5A5_5A5A: performed as a write, so SRAM addr 2=0x5A5A and addr 3=0xA5A5.
- `rst` asserted during HIGH of a read:
  - next cycle is IDLE, `read_data`=0, `sram_we_n`=1;
  - SRAM contents are unchanged;
  - the next read completes normally.
- P=1 and P=15 builds: `ready` low for exactly 3 and 31 cycles respectively. No request gives `ready`=1 constantly.
